midi_parser: RTL and testbench

MIDI_PARSER -- requirements
Module: midi_parser

---
 rtl/midi_parser.sv | 117 +++++++++++
 tb/tb_midi_parser.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/midi_parser.sv
// MIDI byte-stream parser: tracks running status and emits registered note-on/off events.
// Build option: MIDI_PARSER_NOTEON_VEL0_OFF_EN reports note-on with velocity 0 as note-off.
module midi_parser (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] d_in,
  input  logic       d_valid,
  input  logic       f_error,
  output logic       v_valid,
  output logic [3:0] v_channel,
  output logic       v_note_off,
  output logic       v_note_on,
  output logic [6:0] v_note_num,
  output logic [6:0] v_note_velocity
);

  // state   | meaning
  // IDLE    | no running status, data bytes ignored
  // WAIT_D1 | note message, expecting note number
  // WAIT_D2 | note message, expecting velocity
  // SKIP_D1 | non-note message, first of two data bytes to discard
  // SKIP_D2 | non-note message, last data byte to discard
  // SYSEX   | inside system exclusive, data ignored until a status byte
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_D1 = 3'd1,
    WAIT_D2 = 3'd2,
    SKIP_D1 = 3'd3,
    SKIP_D2 = 3'd4,
    SYSEX   = 3'd5
  } state_t;

`ifdef MIDI_PARSER_NOTEON_VEL0_OFF_EN
  localparam logic VEL0_IS_OFF = 1'b1;
`else
  localparam logic VEL0_IS_OFF = 1'b0;
`endif

  state_t     state;
  logic       rs_note_on;
  logic [3:0] rs_channel;
  logic       rs_skip_two;
  logic [6:0] note_num_q;

  logic       is_status;
  logic       is_realtime;
  logic       event_is_on;

  assign is_status   = d_in[7];
  assign is_realtime = (d_in[7:3] == 5'b11111);
  assign event_is_on = rs_note_on && !(VEL0_IS_OFF && (d_in[6:0] == 7'd0));

  always_ff @(posedge clk) begin
    if (reset_n) begin
      state           <= IDLE;
      rs_note_on      <= 1'b0;
      rs_channel      <= 4'd0;
      rs_skip_two     <= 1'b0;
      note_num_q      <= 7'd0;
      v_valid         <= 1'b0;
      v_channel       <= 4'd0;
      v_note_off      <= 1'b0;
      v_note_on       <= 1'b0;
      v_note_num      <= 7'd0;
      v_note_velocity <= 7'd0;
    end else begin
      v_valid    <= 1'b0;
      v_note_on  <= 1'b0;
      v_note_off <= 1'b0;
      if (d_valid) begin
        if (f_error) begin
          state <= IDLE;
        end else if (is_status) begin
          // real-time bytes pass through without touching any state
          if (!is_realtime) begin
            case (d_in[6:4])
              3'b000, 3'b001: begin
                rs_note_on <= d_in[4];
                rs_channel <= d_in[3:0];
                state      <= WAIT_D1;
              end
              3'b010, 3'b011, 3'b110: begin
                rs_skip_two <= 1'b1;
                state       <= SKIP_D1;
              end
              3'b100, 3'b101: begin
                rs_skip_two <= 1'b0;
                state       <= SKIP_D2;
              end
              default: state <= (d_in[3:0] == 4'h0) ? SYSEX : IDLE;
            endcase
          end
        end else begin
          case (state)
            WAIT_D1: begin
              note_num_q <= d_in[6:0];
              state      <= WAIT_D2;
            end
            WAIT_D2: begin
              v_valid         <= 1'b1;
              v_note_on       <= event_is_on;
              v_note_off      <= !event_is_on;
              v_channel       <= rs_channel;
              v_note_num      <= note_num_q;
              v_note_velocity <= d_in[6:0];
              state           <= WAIT_D1;
            end
            SKIP_D1: state <= SKIP_D2;
            SKIP_D2: state <= rs_skip_two ? SKIP_D1 : SKIP_D2;
            default: state <= state;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: byte sequences with hand-computed expected events.
module tb_midi_parser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] d_in;
  logic       d_valid;
  logic       f_error;
  logic       v_valid;
  logic [3:0] v_channel;
  logic       v_note_off;
  logic       v_note_on;
  logic [6:0] v_note_num;
  logic [6:0] v_note_velocity;

  int tests_run = 0;
  int tests_failed = 0;
  int pulses = 0;
  int base;
  logic mon_en = 1'b0;
  logic hit;
  logic ev_on, ev_off;
  logic [3:0] ev_ch;
  logic [6:0] ev_num, ev_vel;
  logic exp_vel0_on;

  midi_parser dut (
    .clk(clk), .reset_n(reset_n), .d_in(d_in), .d_valid(d_valid), .f_error(f_error),
    .v_valid(v_valid), .v_channel(v_channel), .v_note_off(v_note_off),
    .v_note_on(v_note_on), .v_note_num(v_note_num), .v_note_velocity(v_note_velocity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // capture every pulse and keep the flags consistent with v_valid
  always @(negedge clk) begin
    if (mon_en) begin
      if (v_valid === 1'b1) begin
        pulses++;
        ev_on  = v_note_on;
        ev_off = v_note_off;
        ev_ch  = v_channel;
        ev_num = v_note_num;
        ev_vel = v_note_velocity;
        check("onehot", int'(v_note_on) + int'(v_note_off), 1);
      end else begin
        check("flags_idle", {v_note_on, v_note_off}, 0);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic err);
    @(posedge clk); #1;
    d_in = b; d_valid = 1'b1; f_error = err;
    @(posedge clk); #1;
    hit = v_valid;
    d_valid = 1'b0; f_error = 1'b0; d_in = 8'h00;
    repeat (9) @(posedge clk);
  endtask

  task automatic expect_event(input string tag, input logic on, input int ch,
                              input int num, input int vel);
    check({tag, "_count"}, pulses - base, 1);
    check({tag, "_on"}, ev_on, on);
    check({tag, "_off"}, ev_off, !on);
    check({tag, "_ch"}, ev_ch, ch);
    check({tag, "_num"}, ev_num, num);
    check({tag, "_vel"}, ev_vel, vel);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, v_valid, 0);
    check({tag, "_ch"}, v_channel, 0);
    check({tag, "_num"}, v_note_num, 0);
    check({tag, "_vel"}, v_note_velocity, 0);
    check({tag, "_flags"}, {v_note_on, v_note_off}, 0);
  endtask

  initial begin
`ifdef MIDI_PARSER_NOTEON_VEL0_OFF_EN
    exp_vel0_on = 1'b0;
`else
    exp_vel0_on = 1'b1;
`endif
    reset_n = 1'b1; d_in = 8'h00; d_valid = 1'b0; f_error = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_outputs_zero("reset");
    reset_n = 1'b0;
    mon_en = 1'b1;

    base = pulses;
    send(8'h91, 0); send(8'h01, 0); send(8'h02, 0);
    check("first_latency", hit, 1);
    check("first_pulse_end", v_valid, 0);
    expect_event("first", 1, 1, 1, 2);

    base = pulses;
    send(8'h03, 0); send(8'h04, 0);
    check("rs_latency", hit, 1);
    expect_event("running", 1, 1, 3, 4);

    base = pulses;
    send(8'h81, 0); send(8'h03, 0); send(8'h00, 0);
    expect_event("noteoff", 0, 1, 3, 0);

    base = pulses;
    send(8'h91, 0); send(8'h03, 0); send(8'h00, 0);
    expect_event("vel0", exp_vel0_on, 1, 3, 0);

    base = pulses;
    send(8'h90, 0); send(8'h3C, 0); send(8'hF8, 0); send(8'h40, 0);
    expect_event("realtime", 1, 0, 8'h3C, 8'h40);

    base = pulses;
    send(8'hB0, 0); send(8'h07, 0); send(8'h7F, 0); send(8'h07, 0); send(8'h7F, 0);
    check("ctrl_skip_count", pulses - base, 0);
    check("hold_num", v_note_num, 8'h3C);
    check("hold_vel", v_note_velocity, 8'h40);

    base = pulses;
    send(8'hC2, 0); send(8'h05, 0); send(8'h06, 0);
    check("prog_skip_count", pulses - base, 0);

    base = pulses;
    send(8'h92, 0); send(8'h10, 0); send(8'h20, 1); send(8'h30, 0);
    send(8'h40, 0); send(8'h50, 0);
    check("ferr_count", pulses - base, 0);

    base = pulses;
    send(8'h91, 0); send(8'h10, 0); send(8'h92, 0); send(8'h20, 0); send(8'h30, 0);
    expect_event("abandon", 1, 2, 8'h20, 8'h30);

    base = pulses;
    send(8'hF0, 0); send(8'h01, 0); send(8'h02, 0); send(8'h93, 0);
    send(8'h05, 0); send(8'h06, 0);
    expect_event("sysex_exit", 1, 3, 5, 6);

    base = pulses;
    send(8'hF0, 0); send(8'h05, 0); send(8'hF7, 0); send(8'h05, 0); send(8'h06, 0);
    check("sysex_end_count", pulses - base, 0);

    base = pulses;
    send(8'h95, 0); send(8'h11, 0); send(8'hF3, 0); send(8'h22, 0); send(8'h33, 0);
    check("sys_common_count", pulses - base, 0);

    base = pulses;
    send(8'h92, 0); send(8'h10, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("midreset");
    reset_n = 1'b0;
    send(8'h20, 0); send(8'h30, 0);
    check("midreset_count", pulses - base, 0);
    check_outputs_zero("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
